nb_mod_counter: RTL and testbench
=================================

# nb_mod_counter

Parametrised synchronous modulo counter, the general successor to the team's fixed 3-bit JK-flip-flop counters. Runtime-programmable modulus, up/down direction, enable, synchronous load, binary or Gray-coded output, terminal-count and wrap indications, and guaranteed recovery from out-of-range states. Sits in the lab datapath wherever a divide-by-N, sequencer index or event counter is needed.

## Interface
- `WIDTH`, default 4: counter width in bits, legal range 2..16.
- `clk` input 1: single clock; all state updates on the rising edge.
- `clear` input 1: reset, asynchronous, active-low.
- `en` input 1: count enable; one step per cycle while high.
- `up` input 1: direction; 1 = increment, 0 = decrement.
- `load` input 1: synchronous load request.
- `load_val` input WIDTH: value loaded when `load`=1.
- `last` input WIDTH: terminal value, so modulus = `last`+1 (1..2^WIDTH). May change at any time.
- `gray` input 1: output code select; 0 = binary, 1 = Gray.
- `q` output WIDTH: counter value in the selected code.
- `tc` output 1: terminal count, level.
- `wrap` output 1: one-cycle pulse after a wrap step.

## Operation
- Internal state: binary register `cnt` [WIDTH], plus register `wrap`.
- Priority per rising edge: `load` > `en` > hold.
- Load: `cnt` ← `load_val` if `load_val` ≤ `last`, else `cnt` ← `last` (clamp). `wrap` ← 0. Direction and `en` are ignored that cycle.
- Up step (`en`=1, `up`=1): `cnt`=`last` → 0 with `wrap` ← 1. `cnt`<`last` → `cnt`+1. `cnt`>`last` (out of range after `last` was lowered) → 0 with `wrap` ← 0.
- Down step (`en`=1, `up`=0): `cnt`=0 → `last` with `wrap` ← 1. 0<`cnt`≤`last` → `cnt`−1. `cnt`>`last` → `last` with `wrap` ← 0.
- Hold (`en`=0, `load`=0): `cnt` unchanged, `wrap` ← 0.
- `last`=0 (modulus 1): `cnt` stays 0. Every enabled cycle is a wrap step, so `wrap` is high continuously while `en`=1.
- `last`=2^WIDTH−1: plain binary wrap. All arithmetic is modulo 2^WIDTH with no overflow beyond WIDTH.
- `q` = `cnt` when `gray`=0, and `cnt` ^ (`cnt`>>1) when `gray`=1. `q` is a combinational decode of the register, so a `gray` change is visible in the same cycle.
- `tc` = (`up` ? `cnt`=`last` : `cnt`=0). It is combinational, independent of `en`, and 0 when `cnt`>`last` and `up`=1.

## Timing
- Reset (`clear`=0, asynchronous): `cnt`=0, `wrap`=0, so `q`=0. `tc`=1 if `up`=0 or `last`=0, else 0. `clear` asserted mid-count overrides everything immediately. Counting resumes on the first rising edge after release.
- Count and load latency: 1 cycle from input sampling to new `cnt`/`q`.
- `wrap` is registered and high exactly for the cycle following the wrap edge. It aligns with `q` showing 0 (up) or `last` (down).
- `last`, `up` and `gray` are sampled on the same edge as `en`. No setup beyond normal synchronous timing.

## Structure
- Package `nb_count_pkg`:
  - function `bin2gray(logic [WIDTH-1:0])`
  - localparams for legal WIDTH bounds
  - elaboration check that rejects WIDTH outside 2..16
- One sub-module `nb_gray_enc` (parametrised WIDTH, combinational binary→Gray), instantiated on the output path.
- Next-state logic and the `cnt`/`wrap` registers live in `nb_mod_counter`.

## Test plan
All scenarios use WIDTH=4.
- Reset: hold `clear`=0 with `up`=1, `last`=5 → `q`=0, `wrap`=0, `tc`=0. Release, `en`=1 → `q` = 1,2,3,4,5,0. `wrap` high only in the cycle `q` returns to 0. `tc` high when `q`=5.
- Down and Gray: `last`=5, `up`=0, `gray`=1, start from 0 → binary sequence 5,4,3,2,1,0,5 seen as Gray 0111,0110,0010,0011,0001,0000,0111. `wrap`=1 on the step to 5.
- Load: `load_val`=9 with `last`=5 → `cnt`=5. `load`=1 and `en`=1 together with `load_val`=3 → `cnt`=3 and `wrap`=0.
- Out-of-range recovery: count to 12 with `last`=15, then set `last`=4 and step up → `cnt`=0, `wrap`=0, `tc`=0 while at 12. The same setup stepping down gives `cnt`=4.
- Edges: `last`=0, `en`=1 for 3 cycles → `q`=0 and `wrap`=1 each cycle. `last`=15, up from 15 → 0 with `wrap`=1.
- Async reset mid-count: assert `clear` between clock edges at `q`=3 → `q`=0 immediately, with no clock edge needed. `en`=0 for N cycles → `q` holds and `wrap`=0.

Source files
------------

// File: rtl/nb_count_pkg.sv
// nb_count_pkg: shared width bounds and binary-to-Gray helper for the modulo counter
package nb_count_pkg;
  localparam int MIN_WIDTH = 2;
  localparam int MAX_WIDTH = 16;
  function automatic logic [MAX_WIDTH-1:0] bin2gray(input logic [MAX_WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction
endpackage

// File: rtl/nb_mod_counter_if.sv
// nb_mod_counter_if: control inputs and observed outputs of the modulo counter
interface nb_mod_counter_if #(parameter int WIDTH = 4);
  logic             en;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] last;
  logic             gray;
  logic [WIDTH-1:0] q;
  logic             tc;
  logic             wrap;
  modport master (output en, up, load, load_val, last, gray, input q, tc, wrap);
  modport slave (input en, up, load, load_val, last, gray, output q, tc, wrap);
endinterface

// File: rtl/nb_gray_enc.sv
// nb_gray_enc: combinational binary-to-Gray encoder built on the package helper
module nb_gray_enc
  import nb_count_pkg::*;
#(parameter int WIDTH = 4) (
  input  logic [WIDTH-1:0] bin_i,
  output logic [WIDTH-1:0] gray_o
);
  logic [MAX_WIDTH-1:0] gray_full;
  logic                 unused_hi;
  assign gray_full = bin2gray(MAX_WIDTH'(bin_i));
  assign gray_o    = gray_full[WIDTH-1:0];
  assign unused_hi = &{1'b0, gray_full};
endmodule

// File: rtl/nb_mod_counter.sv
// nb_mod_counter: programmable-modulus up/down counter with load, Gray output, tc and wrap
module nb_mod_counter
  import nb_count_pkg::*;
#(parameter int WIDTH = 4) (
  input logic           clk,
  input logic           clear,
  nb_mod_counter_if.slave bus
);
  if (WIDTH < MIN_WIDTH || WIDTH > MAX_WIDTH) begin : g_width_chk
    $error("nb_mod_counter: WIDTH must be within 2..16");
  end
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             wrap_q, wrap_d;
  logic [WIDTH-1:0] gray_w;
  logic             at_last, at_zero, above;
  assign at_last = cnt_q == bus.last;
  assign at_zero = cnt_q == '0;
  assign above   = cnt_q > bus.last;
  // Next state: load beats enable; out-of-range values snap back to 0 (up) or last (down) without a wrap pulse
  always_comb begin
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    if (bus.load) begin
      cnt_d = (bus.load_val <= bus.last) ? bus.load_val : bus.last;
    end else if (bus.en) begin
      cnt_d  = bus.up ? ((at_last || above) ? '0 : cnt_q + WIDTH'(1))
                      : ((at_zero || above) ? bus.last : cnt_q - WIDTH'(1));
      wrap_d = bus.up ? at_last : at_zero;
    end
  end
  // Counter and wrap registers, cleared asynchronously
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      cnt_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
    end
  end
  nb_gray_enc #(.WIDTH(WIDTH)) u_gray (.bin_i(cnt_q), .gray_o(gray_w));
  assign bus.q    = bus.gray ? gray_w : cnt_q;
  assign bus.tc   = bus.up ? at_last : at_zero;
  assign bus.wrap = wrap_q;
endmodule

// File: tb/tb_nb_mod_counter.sv
// tb_nb_mod_counter: directed vector table plus hand sequences for the modulo counter
module tb_nb_mod_counter;
  typedef struct {
    logic       ld;
    logic [3:0] lv;
    logic       en;
    logic       up;
    logic [3:0] last;
    logic       g;
    logic [3:0] q;
    logic       tc;
    logic       w;
  } vec_t;
  logic clk;
  logic clear;
  int   checks;
  int   failures;
  vec_t tv[$];
  nb_mod_counter_if #(.WIDTH(4)) bus ();
  nb_mod_counter #(.WIDTH(4)) dut (.clk(clk), .clear(clear), .bus(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask
  task automatic run_vec(input vec_t v, input int idx);
    bus.load     = v.ld;
    bus.load_val = v.lv;
    bus.en       = v.en;
    bus.up       = v.up;
    bus.last     = v.last;
    bus.gray     = v.g;
    @(posedge clk);
    #1;
    chk($sformatf("vec%0d_q", idx), bus.q, v.q);
    chk($sformatf("vec%0d_tc", idx), {3'b0, bus.tc}, {3'b0, v.tc});
    chk($sformatf("vec%0d_wrap", idx), {3'b0, bus.wrap}, {3'b0, v.w});
  endtask
  initial begin
    checks   = 0;
    failures = 0;
    //                ld lv     en up last  g  q      tc w
    tv.push_back('{1'b0, 4'd0, 1'b1, 1'b1, 4'd5, 1'b0, 4'd1, 1'b0, 1'b0});
    tv.push_back('{1'b0, 4'd0, 1'b1, 1'b1, 4'd5, 1'b0, 4'd2, 1'b0, 1'b0});
    tv.push_back('{1'b0, 4'd0, 1'b1, 1'b1, 4'd5, 1'b0, 4'd3, 1'b0, 1'b0});
    tv.push_back('{1'b0, 4'd0, 1'b1, 1'b1, 4'd5, 1'b0, 4'd4, 1'b0, 1'b0});
    tv.push_back('{1'b0, 4'd0, 1'b1, 1'b1, 4'd5, 1'b0, 4'd5, 1'b1, 1'b0});
    tv.push_back('{1'b0, 4'd0, 1'b1, 1'b1, 4'd5, 1'b0, 4'd0, 1'b0, 1'b1});
    tv.push_back('{1'b0, 4'd0, 1'b1, 1'b0, 4'd5, 1'b1, 4'b0111, 1'b0, 1'b1});
    tv.push_back('{1'b0, 4'd0, 1'b1, 1'b0, 4'd5, 1'b1, 4'b0110, 1'b0, 1'b0});
    tv.push_back('{1'b0, 4'd0, 1'b1, 1'b0, 4'd5, 1'b1, 4'b0010, 1'b0, 1'b0});
    tv.push_back('{1'b0, 4'd0, 1'b1, 1'b0, 4'd5, 1'b1, 4'b0011, 1'b0, 1'b0});
    tv.push_back('{1'b0, 4'd0, 1'b1, 1'b0, 4'd5, 1'b1, 4'b0001, 1'b0, 1'b0});
    tv.push_back('{1'b0, 4'd0, 1'b1, 1'b0, 4'd5, 1'b1, 4'b0000, 1'b1, 1'b0});
    tv.push_back('{1'b0, 4'd0, 1'b1, 1'b0, 4'd5, 1'b1, 4'b0111, 1'b0, 1'b1});
    tv.push_back('{1'b1, 4'd9, 1'b0, 1'b1, 4'd5, 1'b0, 4'd5, 1'b1, 1'b0});
    tv.push_back('{1'b1, 4'd3, 1'b1, 1'b1, 4'd5, 1'b0, 4'd3, 1'b0, 1'b0});
    tv.push_back('{1'b1, 4'd12, 1'b0, 1'b1, 4'd15, 1'b0, 4'd12, 1'b0, 1'b0});
    tv.push_back('{1'b0, 4'd0, 1'b0, 1'b1, 4'd4, 1'b0, 4'd12, 1'b0, 1'b0});
    tv.push_back('{1'b0, 4'd0, 1'b1, 1'b1, 4'd4, 1'b0, 4'd0, 1'b0, 1'b0});
    tv.push_back('{1'b1, 4'd12, 1'b0, 1'b1, 4'd15, 1'b0, 4'd12, 1'b0, 1'b0});
    tv.push_back('{1'b0, 4'd0, 1'b1, 1'b0, 4'd4, 1'b0, 4'd4, 1'b0, 1'b0});
    tv.push_back('{1'b1, 4'd0, 1'b0, 1'b1, 4'd0, 1'b0, 4'd0, 1'b1, 1'b0});
    tv.push_back('{1'b0, 4'd0, 1'b1, 1'b1, 4'd0, 1'b0, 4'd0, 1'b1, 1'b1});
    tv.push_back('{1'b0, 4'd0, 1'b1, 1'b1, 4'd0, 1'b0, 4'd0, 1'b1, 1'b1});
    tv.push_back('{1'b0, 4'd0, 1'b1, 1'b1, 4'd0, 1'b0, 4'd0, 1'b1, 1'b1});
    tv.push_back('{1'b0, 4'd0, 1'b0, 1'b1, 4'd0, 1'b0, 4'd0, 1'b1, 1'b0});
    tv.push_back('{1'b1, 4'd15, 1'b0, 1'b1, 4'd15, 1'b0, 4'd15, 1'b1, 1'b0});
    tv.push_back('{1'b0, 4'd0, 1'b1, 1'b1, 4'd15, 1'b0, 4'd0, 1'b0, 1'b1});
    tv.push_back('{1'b0, 4'd0, 1'b1, 1'b1, 4'd15, 1'b0, 4'd1, 1'b0, 1'b0});
    tv.push_back('{1'b0, 4'd0, 1'b0, 1'b1, 4'd15, 1'b0, 4'd1, 1'b0, 1'b0});
    tv.push_back('{1'b0, 4'd0, 1'b0, 1'b1, 4'd15, 1'b0, 4'd1, 1'b0, 1'b0});
    tv.push_back('{1'b0, 4'd0, 1'b0, 1'b1, 4'd15, 1'b0, 4'd1, 1'b0, 1'b0});
    tv.push_back('{1'b0, 4'd0, 1'b1, 1'b1, 4'd15, 1'b0, 4'd2, 1'b0, 1'b0});
    tv.push_back('{1'b0, 4'd0, 1'b1, 1'b1, 4'd15, 1'b0, 4'd3, 1'b0, 1'b0});
    clear        = 1'b0;
    bus.load     = 1'b0;
    bus.load_val = '0;
    bus.en       = 1'b1;
    bus.up       = 1'b1;
    bus.last     = 4'd5;
    bus.gray     = 1'b0;
    #12;
    chk("rst_q", bus.q, 4'd0);
    chk("rst_wrap", {3'b0, bus.wrap}, 4'd0);
    chk("rst_tc_up", {3'b0, bus.tc}, 4'd0);
    bus.up = 1'b0;
    #1;
    chk("rst_tc_down", {3'b0, bus.tc}, 4'd1);
    bus.up = 1'b1;
    @(negedge clk);
    clear = 1'b1;
    for (int i = 0; i < tv.size(); i++) run_vec(tv[i], i);
    #2;
    bus.gray = 1'b1;
    #1;
    chk("gray_comb_q", bus.q, 4'b0010);
    bus.gray = 1'b0;
    clear = 1'b0;
    #1;
    chk("async_clr_q", bus.q, 4'd0);
    chk("async_clr_tc", {3'b0, bus.tc}, 4'd0);
    #2;
    clear = 1'b1;
    run_vec('{1'b0, 4'd0, 1'b1, 1'b1, 4'd15, 1'b0, 4'd1, 1'b0, 1'b0}, 100);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
